regbank_access_ctrl: RTL and testbench

//   Initiator side of the register-bank port. Accepts READ/WRITE/INCR/CLEAR

---
 rtl/regbank_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_regbank_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_access_ctrl.sv
// Initiator-side controller for register_bank: sequences READ/WRITE/INCR/CLEAR
// commands onto the bank's single write port and async read port, one response per command.
module regbank_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_carry,
    output logic              busy,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_write_addr,
    output logic [DATA_W-1:0] bank_write_data,
    output logic [ADDR_W-1:0] bank_read_addr,
    input  logic [DATA_W-1:0] bank_read_data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              carry_q;
    logic              accept;
    logic              rsp_done;
    logic [DATA_W-1:0] incr_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_READ || cmd_op == OP_INCR) begin
                        next_state = RD;
                    end else begin
                        next_state = WR;
                    end
                end
            end
            RD: begin
                if (op_q == OP_INCR) begin
                    next_state = WR;
                end else begin
                    next_state = RESP;
                end
            end
            WR: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        accept     = (state == IDLE) && cmd_valid && cmd_ready;
        rsp_done   = (state == RESP) && rsp_valid && rsp_ready;
        incr_value = bank_read_data + {{(DATA_W-1){1'b0}}, 1'b1};
    end

    // Datapath: every bank-facing and response output is a register, so the
    // bank sees clean, glitch-free controls and bank_we lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready       <= 1'b0;
            op_q            <= '0;
            addr_q          <= '0;
            carry_q         <= 1'b0;
            bank_we         <= 1'b0;
            bank_write_addr <= '0;
            bank_write_data <= '0;
            bank_read_addr  <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            rsp_carry       <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            bank_we   <= 1'b0;

            if (accept) begin
                op_q            <= cmd_op;
                addr_q          <= cmd_addr;
                carry_q         <= 1'b0;
                bank_read_addr  <= cmd_addr;
                bank_write_addr <= cmd_addr;
                bank_write_data <= (cmd_op == OP_WRITE) ? cmd_data : '0;
                bank_we         <= (cmd_op == OP_WRITE || cmd_op == OP_CLEAR) &&
                                   (cmd_addr != '0);
            end

            if (state == RD) begin
                if (op_q == OP_INCR) begin
                    bank_write_data <= incr_value;
                    carry_q         <= &bank_read_data;
                    bank_we         <= (addr_q != '0);
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= bank_read_data;
                    rsp_err   <= 1'b0;
                    rsp_carry <= 1'b0;
                end
            end

            // Register 0 is read-only: the write was suppressed, so report 0 and flag it.
            if (state == WR) begin
                rsp_valid <= 1'b1;
                rsp_data  <= (addr_q == '0) ? '0 : bank_write_data;
                rsp_err   <= (addr_q == '0);
                rsp_carry <= (op_q == OP_INCR) && carry_q;
            end

            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rsp_data  <= '0;
                rsp_err   <= 1'b0;
                rsp_carry <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Bench for regbank_access_ctrl: a register-bank stand-in, a transaction-level
// model of expected responses and bank writes, and a per-cycle compare process.
module tb_regbank_access_ctrl;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INCR  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_carry;
    logic       busy;
    logic       bank_we;
    logic [2:0] bank_write_addr;
    logic [7:0] bank_write_data;
    logic [2:0] bank_read_addr;
    logic [7:0] bank_read_data;

    int pass_count  = 0;
    int check_count = 0;
    int we_count    = 0;

    regbank_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_carry      (rsp_carry),
        .busy           (busy),
        .bank_we        (bank_we),
        .bank_write_addr(bank_write_addr),
        .bank_write_data(bank_write_data),
        .bank_read_addr (bank_read_addr),
        .bank_read_data (bank_read_data)
    );

    always #5 clk = ~clk;

    // Register bank stand-in: register 0 hardwired to zero, async read.
    logic [7:0] init_vals [8];
    logic [7:0] bank_mem [8];
    bit         bank_loaded = 1'b0;

    always @(posedge clk) begin
        if (!bank_loaded) begin
            for (int i = 0; i < 8; i++) bank_mem[i] <= init_vals[i];
            bank_loaded <= 1'b1;
        end else if (bank_we === 1'b1 && bank_write_addr != 3'd0) begin
            bank_mem[bank_write_addr] <= bank_write_data;
        end
        if (bank_we === 1'b1) we_count++;
    end

    assign bank_read_data = bank_mem[bank_read_addr];

    // Transaction-level model: one outstanding command, its response is due a
    // fixed number of edges after acceptance and its write lands on that edge.
    logic [7:0] ref_regs [8];
    bit         ref_loaded = 1'b0;
    bit         pending    = 1'b0;
    bit         rst_seen   = 1'b1;
    int         cyc        = 0;
    int         due        = 0;
    int         acc_cyc    = 0;
    logic [1:0] p_op;
    logic [2:0] p_addr;
    logic [7:0] p_wdata;
    logic [7:0] e_data;
    bit         e_err;
    bit         e_carry;
    bit         started = 1'b0;

    always @(posedge clk) begin
        bit         ready_prev;
        bit         valid_prev;
        logic [7:0] cur;
        if (!ref_loaded) begin
            for (int i = 0; i < 8; i++) ref_regs[i] = init_vals[i];
            ref_loaded = 1'b1;
        end
        ready_prev = !pending && !rst_seen;
        valid_prev = pending && (cyc >= due);
        cyc = cyc + 1;
        if (pending && cyc == due && p_op != OP_READ && p_addr != 3'd0)
            ref_regs[p_addr] = p_wdata;
        if (rst) begin
            pending  = 1'b0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (valid_prev && rsp_ready) begin
                pending = 1'b0;
            end else if (ready_prev && cmd_valid) begin
                pending = 1'b1;
                p_op    = cmd_op;
                p_addr  = cmd_addr;
                acc_cyc = cyc;
                cur     = ref_regs[cmd_addr];
                e_carry = 1'b0;
                case (cmd_op)
                    OP_READ:  p_wdata = 8'h00;
                    OP_WRITE: p_wdata = cmd_data;
                    OP_CLEAR: p_wdata = 8'h00;
                    default: begin
                        p_wdata = cur + 8'd1;
                        e_carry = (cur == 8'hFF);
                    end
                endcase
                due = cyc + ((cmd_op == OP_INCR) ? 2 : 1);
                if (cmd_op == OP_READ) begin
                    e_data = cur;
                    e_err  = 1'b0;
                end else begin
                    e_err  = (cmd_addr == 3'd0);
                    e_data = (cmd_addr == 3'd0) ? 8'h00 : p_wdata;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        check_count++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_we;
        bit exp_rd;
        if (started) begin
            exp_valid = pending && (cyc >= due);
            exp_we    = pending && p_op != OP_READ && p_addr != 3'd0 && cyc == due - 1;
            exp_rd    = pending && (p_op == OP_READ || p_op == OP_INCR) && cyc == acc_cyc;
            check_output("cmd_ready", 32'(cmd_ready), 32'(!pending && !rst_seen));
            check_output("busy", 32'(busy), 32'(pending));
            check_output("bank_we", 32'(bank_we), 32'(exp_we));
            if (exp_we) begin
                check_output("bank_write_addr", 32'(bank_write_addr), 32'(p_addr));
                check_output("bank_write_data", 32'(bank_write_data), 32'(p_wdata));
            end
            if (exp_rd) check_output("bank_read_addr", 32'(bank_read_addr), 32'(p_addr));
            check_output("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check_output("rsp_data", 32'(rsp_data), exp_valid ? 32'(e_data) : 32'd0);
            check_output("rsp_err", 32'(rsp_err), exp_valid ? 32'(e_err) : 32'd0);
            check_output("rsp_carry", 32'(rsp_carry), exp_valid ? 32'(e_carry) : 32'd0);
        end
    end

    task automatic wait_accept(output bit ok);
        int t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (cmd_ready === 1'b1);
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            note_timeout("accept");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic [2:0] addr,
                                  input logic [7:0] data, input int hold, input bit poke,
                                  output logic [7:0] r_data, output bit r_err,
                                  output bit r_carry);
        bit ok;
        int t = 0;
        r_data    = 8'h00;
        r_err     = 1'b0;
        r_carry   = 1'b0;
        rsp_ready = 1'b0;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_accept(ok);
        if (!ok) return;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (rsp_valid !== 1'b1) begin
            note_timeout("response");
            return;
        end
        if (poke) begin
            cmd_op    = OP_WRITE;
            cmd_addr  = addr;
            cmd_data  = 8'h11;
            cmd_valid = 1'b1;
        end
        repeat (hold) @(negedge clk);
        r_data    = rsp_data;
        r_err     = rsp_err;
        r_carry   = rsp_carry;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    bit         re;
    bit         rc;
    int         we_before;
    bit         ok;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_READ;
        cmd_addr  = 3'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) init_vals[i] = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("reset_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_output("reset_cmd_ready_high", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] write/read addr3");
        we_before = we_count;
        apply_stimulus(OP_WRITE, 3'd3, 8'hAA, 0, 1'b0, rd, re, rc);
        check_output("t1_we_pulses", 32'(we_count - we_before), 32'd1);
        apply_stimulus(OP_READ, 3'd3, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t1_read_data", 32'(rd), 32'hAA);
        check_output("t1_read_err", 32'(re), 32'd0);

        $display("[TB] incr wrap addr5");
        apply_stimulus(OP_WRITE, 3'd5, 8'hFF, 0, 1'b0, rd, re, rc);
        we_before = we_count;
        apply_stimulus(OP_INCR, 3'd5, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t2_incr_we_pulses", 32'(we_count - we_before), 32'd1);
        check_output("t2_incr_wrap_data", 32'(rd), 32'h00);
        check_output("t2_incr_wrap_carry", 32'(rc), 32'd1);
        apply_stimulus(OP_INCR, 3'd5, 8'h00, 1, 1'b0, rd, re, rc);
        check_output("t2_incr_data", 32'(rd), 32'h01);
        check_output("t2_incr_carry", 32'(rc), 32'd0);

        $display("[TB] addr0 protection");
        we_before = we_count;
        apply_stimulus(OP_WRITE, 3'd0, 8'hFF, 0, 1'b0, rd, re, rc);
        check_output("t3_addr0_we_pulses", 32'(we_count - we_before), 32'd0);
        check_output("t3_addr0_err", 32'(re), 32'd1);
        check_output("t3_addr0_data", 32'(rd), 32'h00);
        apply_stimulus(OP_READ, 3'd0, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t3_read0_data", 32'(rd), 32'h00);
        check_output("t3_read0_err", 32'(re), 32'd0);

        $display("[TB] response backpressure");
        apply_stimulus(OP_READ, 3'd3, 8'h00, 5, 1'b1, rd, re, rc);
        check_output("t4_held_data", 32'(rd), 32'hAA);
        apply_stimulus(OP_READ, 3'd3, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t4_ignored_cmd", 32'(rd), 32'hAA);

        $display("[TB] clear addr5");
        apply_stimulus(OP_WRITE, 3'd5, 8'h55, 0, 1'b0, rd, re, rc);
        we_before = we_count;
        apply_stimulus(OP_CLEAR, 3'd5, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t5_clear_we_pulses", 32'(we_count - we_before), 32'd1);
        check_output("t5_clear_data", 32'(rd), 32'h00);
        apply_stimulus(OP_READ, 3'd5, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t5_read_after_clear", 32'(rd), 32'h00);

        $display("[TB] reset during incr");
        apply_stimulus(OP_WRITE, 3'd2, 8'h33, 0, 1'b0, rd, re, rc);
        we_before = we_count;
        cmd_op    = OP_INCR;
        cmd_addr  = 3'd2;
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        wait_accept(ok);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("t6_ready_after_rst", 32'(cmd_ready), 32'd0);
        check_output("t6_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_output("t6_ready_restored", 32'(cmd_ready), 32'd1);
        check_output("t6_no_we", 32'(we_count - we_before), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(OP_READ, 3'd2, 8'h00, 0, 1'b0, rd, re, rc);
        check_output("t6_addr2_unchanged", 32'(rd), 32'h33);

        $display("[TB] randomized commands");
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [2:0] addr;
            logic [7:0] data;
            int         k;
            op   = 2'($urandom_range(0, 3));
            addr = 3'($urandom_range(0, 7));
            data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                rsp_ready = 1'b0;
                cmd_op    = op;
                cmd_addr  = addr;
                cmd_data  = data;
                cmd_valid = 1'b1;
                wait_accept(ok);
                k = $urandom_range(0, 3);
                repeat (k) @(posedge clk);
                if (k > 0) #1;
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                apply_stimulus(op, addr, data, $urandom_range(0, 3),
                               ($urandom_range(0, 3) == 0), rd, re, rc);
                k = $urandom_range(0, 2);
                repeat (k) @(posedge clk);
                if (k > 0) #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
